sparse_weight_encoder: RTL
==========================

// Module: sparse_weight_encoder
// PURPOSE
//  Compresses one filter's dense KxK kernel over all input channels into the sparse format consumed
//  by cnn_layer/vector_generator: packed non-zero values, per-value column index, per-row cumulative
//  row pointer. Encoder side of the decoder in vector_generator; run once per filter when weights load.
// PARAMETERS
//  IN_CHANNELS        3  input channels per kernel
//  KER_SIZE           3  kernel width/height; rows = IN_CHANNELS*KER_SIZE, beats = rows*KER_SIZE
//  NON_ZERO_WEIGHTS   6  capacity of compressed value/index slots
//  BIT_SIZE          16  weight width (fixed point, signed)
//  INDEX_BIT_SIZE     3  column index width; require KER_SIZE <= 2**INDEX_BIT_SIZE
//  R_POINTER_BIT_SIZE 3  row pointer width; require NON_ZERO_WEIGHTS < 2**R_POINTER_BIT_SIZE
// PORTS
//  clk        in   1   clock, all state on posedge
//  rst        in   1   reset, asynchronous, active-high
//  start      in   1   pulse: clear state, begin accepting a kernel
//  in_data    in   BIT_SIZE  dense weight, order channel -> row -> column (column fastest)
//  in_valid   in   1   in_data valid
//  in_ready   out  1   encoder accepts a beat when in_valid & in_ready
//  weights    out  NON_ZERO_WEIGHTS*BIT_SIZE  slot k at [k*BIT_SIZE +: BIT_SIZE], slot 0 = first non-zero
//  index      out  NON_ZERO_WEIGHTS*INDEX_BIT_SIZE  column (0..KER_SIZE-1) of slot k
//  r_pointer  out  IN_CHANNELS*KER_SIZE*R_POINTER_BIT_SIZE  row j = non-zeros in rows 0..j
//  nz_count   out  R_POINTER_BIT_SIZE  non-zeros stored so far
//  out_valid  out  1   packed outputs complete and stable
//  done       out  1   one-cycle pulse when kernel finishes
//  overflow   out  1   sticky: more non-zeros than NON_ZERO_WEIGHTS were seen
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE; all outputs 0, including in_ready, done, out_valid, overflow.
//  - FSM IDLE -> LOAD on start; LOAD -> DONE on acceptance of last beat (row=rows-1, col=KER_SIZE-1);
//    DONE -> IDLE after one cycle; start in any state -> LOAD with weights/index/r_pointer/nz_count/
//    overflow/out_valid/counters cleared the same edge (abort and restart mid-LOAD).
//  - in_ready = 1 only in LOAD (registered-state decode, not dependent on in_valid).
//  - Per accepted beat: if in_data != 0 and nz_count < NON_ZERO_WEIGHTS: slot[nz_count] <= in_data,
//    index slot <= col, nz_count++. If in_data != 0 and full: discard, overflow <= 1. Zero: no store.
//  - On col = KER_SIZE-1: r_pointer[row] <= nz_count including this beat's increment; col wraps to 0, row++.
//  - No accept in a cycle (in_valid=0) -> counters hold; gaps of any length allowed.
//  - done high the cycle after the last beat is accepted (state DONE); out_valid set same edge and held
//    until next start or rst. Unused slots remain 0. Outputs only change on accepted beats/start/rst.
//  - Latency: start at edge 0 -> in_ready high cycle 1; with continuous in_valid, beats accepted cycles
//    1..N (N=IN_CHANNELS*KER_SIZE**2), done in cycle N+1.
//  - start and in_valid in the same LOAD cycle: start wins, beat dropped.
// STRUCTURE
//  - Shared package cnn_sparse_pkg: localparams ROWS, BEATS, counter widths ($clog2), state encoding
//    (IDLE, LOAD, DONE), elaboration checks on INDEX/R_POINTER widths.
//  - Single module; no sub-module. Row/col counters + nz_count + packed registers, indexed-part-select writes.
// TESTING (defaults, 27 beats)
//  1 All 27 beats zero -> done cycle 28, nz_count 0, all outputs 0, overflow 0.
//  2 Non-zero 0x0100 @beat0, 0xFF00 @beat4, 0x0080 @beat26 -> slots 0..2 = 0100,FF00,0080; index 0,1,2;
//    r_pointer rows0..8 = 1,2,2,2,2,2,2,2,3; nz_count 3; slots 3..5 = 0.
//  3 Seven non-zeros (beats 0..6 = 1..7) -> slots hold 1..6, overflow 1, nz_count 6, r_pointer row8 = 6.
//  4 in_valid toggled 1-0-1 randomly -> identical outputs to scenario 2; done one cycle after 27th accept.
//  5 rst asserted mid-LOAD (beat 10) asynchronously -> all outputs 0 before next edge, in_ready 0.
//  6 start re-pulsed at beat 12 then scenario 2 stream -> results equal scenario 2, overflow 0.

Source files
------------

// File: rtl/cnn_sparse_pkg.sv
// Shared definitions for the sparse weight encoder/decoder pair: default geometry,
// FSM state encoding and a counter-width helper.
package cnn_sparse_pkg;

  localparam int IN_CHANNELS_DEF        = 3;
  localparam int KER_SIZE_DEF           = 3;
  localparam int NON_ZERO_WEIGHTS_DEF   = 6;
  localparam int BIT_SIZE_DEF           = 16;
  localparam int INDEX_BIT_SIZE_DEF     = 3;
  localparam int R_POINTER_BIT_SIZE_DEF = 3;

  localparam int ROWS  = IN_CHANNELS_DEF * KER_SIZE_DEF;
  localparam int BEATS = ROWS * KER_SIZE_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } enc_state_e;

  // Width of a counter covering 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sparse_weight_encoder.sv
// Compresses one filter's dense KxK x IN_CHANNELS kernel into packed non-zero values,
// per-value column indices and per-row cumulative row pointers.
module sparse_weight_encoder
  import cnn_sparse_pkg::*;
#(
  parameter int IN_CHANNELS        = IN_CHANNELS_DEF,
  parameter int KER_SIZE           = KER_SIZE_DEF,
  parameter int NON_ZERO_WEIGHTS   = NON_ZERO_WEIGHTS_DEF,
  parameter int BIT_SIZE           = BIT_SIZE_DEF,
  parameter int INDEX_BIT_SIZE     = INDEX_BIT_SIZE_DEF,
  parameter int R_POINTER_BIT_SIZE = R_POINTER_BIT_SIZE_DEF
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             start,
  input  logic [BIT_SIZE-1:0]                              in_data,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  output logic [NON_ZERO_WEIGHTS*BIT_SIZE-1:0]             weights,
  output logic [NON_ZERO_WEIGHTS*INDEX_BIT_SIZE-1:0]       index,
  output logic [IN_CHANNELS*KER_SIZE*R_POINTER_BIT_SIZE-1:0] r_pointer,
  output logic [R_POINTER_BIT_SIZE-1:0]                    nz_count,
  output logic                                             out_valid,
  output logic                                             done,
  output logic                                             overflow,
  output enc_state_e                                       fsm_state
);

  localparam int N_ROWS = IN_CHANNELS * KER_SIZE;
  localparam int COL_W  = cnt_width(KER_SIZE);
  localparam int ROW_W  = cnt_width(N_ROWS);
  localparam int RPW    = R_POINTER_BIT_SIZE;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(KER_SIZE - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_ROWS - 1);
  localparam logic [RPW-1:0]   NZ_CAP   = RPW'(NON_ZERO_WEIGHTS);

  if (KER_SIZE > (2 ** INDEX_BIT_SIZE)) begin : g_bad_index_width
    $error("INDEX_BIT_SIZE too narrow for KER_SIZE");
  end
  if (NON_ZERO_WEIGHTS >= (2 ** R_POINTER_BIT_SIZE)) begin : g_bad_rptr_width
    $error("R_POINTER_BIT_SIZE too narrow for NON_ZERO_WEIGHTS");
  end

  enc_state_e       state;
  logic [COL_W-1:0] col_cnt;
  logic [ROW_W-1:0] row_cnt;
  logic             is_nz;
  logic             has_room;
  logic             store;
  logic [RPW-1:0]   nz_next;

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready and start is low;
  // in_ready is a pure decode of the registered state, so it never depends on in_valid.
  assign in_ready  = (state == LOAD);
  assign fsm_state = state;

  assign is_nz    = (in_data != '0);
  assign has_room = (nz_count < NZ_CAP);
  assign store    = is_nz && has_room;
  assign nz_next  = nz_count + RPW'(store);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      col_cnt   <= '0;
      row_cnt   <= '0;
      weights   <= '0;
      index     <= '0;
      r_pointer <= '0;
      nz_count  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // Start aborts whatever is in flight, including a beat offered this cycle.
        state     <= LOAD;
        col_cnt   <= '0;
        row_cnt   <= '0;
        weights   <= '0;
        index     <= '0;
        r_pointer <= '0;
        nz_count  <= '0;
        out_valid <= 1'b0;
        overflow  <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          LOAD: begin
            if (in_valid) begin
              for (int k = 0; k < NON_ZERO_WEIGHTS; k++) begin
                if (store && (nz_count == RPW'(k))) begin
                  weights[k*BIT_SIZE +: BIT_SIZE]           <= in_data;
                  index[k*INDEX_BIT_SIZE +: INDEX_BIT_SIZE] <= INDEX_BIT_SIZE'(col_cnt);
                end
              end
              nz_count <= nz_next;
              if (is_nz && !has_room) overflow <= 1'b1;

              if (col_cnt == LAST_COL) begin
                for (int j = 0; j < N_ROWS; j++) begin
                  if (row_cnt == ROW_W'(j)) r_pointer[j*RPW +: RPW] <= nz_next;
                end
                col_cnt <= '0;
                row_cnt <= row_cnt + 1'b1;
                if (row_cnt == LAST_ROW) begin
                  state     <= DONE;
                  done      <= 1'b1;
                  out_valid <= 1'b1;
                end
              end else begin
                col_cnt <= col_cnt + 1'b1;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
